// File: rtl/mem_stage_lsu_if.sv
// Valid/ready data-bus bundle between the memory-stage LSU (master) and
// the data memory or interconnect (slave).
interface mem_stage_lsu_if #(
  parameter int XLEN = 32
);
  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [3:0]      bus_be;
  logic            bus_ready;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory stage: EX/MEM register plus a load/store unit on a valid/ready bus.
// Optional bus-wait abort is enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu #(
  parameter int XLEN = 32
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flushE,
  input  logic            rf_enE,
  input  logic [1:0]      wb_selE,
  input  logic            mem_rdE,
  input  logic            mem_wrE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] alu_outE,
  input  logic [XLEN-1:0] store_dataE,
  input  logic [4:0]      rdE,
  output logic            stall_mem,
  output logic            rf_enM,
  output logic [1:0]      wb_selM,
  output logic [4:0]      rdM,
  output logic [XLEN-1:0] alu_outM,
  output logic [XLEN-1:0] load_dataM,
  output logic            misalignedM,
`ifdef LSU_TIMEOUT_EN
  output logic            bus_errM,
`endif
  mem_stage_lsu_if.master bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic            rf_en;
    logic [1:0]      wb_sel;
    logic            mem_rd;
    logic            mem_wr;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
  } exmem_t;

  function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                               input logic [1:0] a,
                                               input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = rdata[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] sd);
    case (f3[1:0])
      2'b00:   return {(XLEN/8){sd[7:0]}};
      2'b01:   return {(XLEN/16){sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  state_t state_q, state_d;
  exmem_t exm_q, exm_d;

  logic       is_load, is_store, is_mem, bad_f3, misal, illegal, legal_mem;
  logic       req_raw, abort, bubble;
  logic [2:0] f3;
  logic [1:0] a;

  assign f3       = exm_q.funct3;
  assign a        = exm_q.alu_out[1:0];
  assign is_load  = exm_q.mem_rd;
  assign is_store = exm_q.mem_wr & ~exm_q.mem_rd;
  assign is_mem   = is_load | is_store;

  assign bad_f3    = is_load ? ((f3 == 3'b011) || (f3[2:1] == 2'b11))
                             : (f3[2] || (f3[1:0] == 2'b11));
  assign misal     = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  assign illegal   = is_mem & (bad_f3 | misal);
  assign legal_mem = is_mem & ~illegal;

  // ACCESS keeps the request up even though the held op already implies it;
  // the first cycle of an access requests combinationally from IDLE.
  assign req_raw = (state_q == ACCESS) | legal_mem;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign abort    = req_raw & (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign cnt_d    = (req_raw & ~bus.bus_ready & ~abort) ? cnt_q + 1'b1 : '0;
  assign bus_errM = abort;
`else
  assign abort = 1'b0;
`endif

  assign bus.bus_req   = req_raw & ~abort;
  assign bus.bus_we    = bus.bus_req & is_store;
  assign bus.bus_addr  = {exm_q.alu_out[XLEN-1:2], 2'b00};
  assign bus.bus_wdata = store_wdata(f3, exm_q.store_data);
  assign bus.bus_be    = (bus.bus_req & is_store) ? store_be(f3, a) : 4'b0000;

  // MEM/WB cannot stall, so every non-completing cycle must look like a bubble.
  assign stall_mem   = bus.bus_req & ~bus.bus_ready;
  assign bubble      = stall_mem | illegal | abort;
  assign rf_enM      = exm_q.rf_en & ~bubble;
  assign wb_selM     = bubble ? 2'b00 : exm_q.wb_sel;
  assign rdM         = exm_q.rd;
  assign alu_outM    = exm_q.alu_out;
  assign misalignedM = illegal;
  assign load_dataM  = (is_load & ~illegal) ? load_ext(f3, a, bus.bus_rdata) : '0;

  assign state_d = stall_mem ? ACCESS : IDLE;

  always_comb begin
    exm_d = exm_q;
    if (!stall_mem) begin
      exm_d.rf_en      = rf_enE  & ~flushE;
      exm_d.mem_rd     = mem_rdE & ~flushE;
      exm_d.mem_wr     = mem_wrE & ~flushE;
      exm_d.wb_sel     = flushE ? 2'b00 : wb_selE;
      exm_d.funct3     = funct3E;
      exm_d.alu_out    = alu_outE;
      exm_d.store_data = store_dataE;
      exm_d.rd         = rdE;
    end
  end

  // EX/MEM capture boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      exm_q   <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      exm_q   <= exm_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed vector table, reset and
// timeout sequences, and randomized ops checked against an arithmetic model.
module tb_mem_stage_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        flushE, rf_enE, mem_rdE, mem_wrE;
  logic [1:0]  wb_selE;
  logic [2:0]  funct3E;
  logic [31:0] alu_outE, store_dataE;
  logic [4:0]  rdE;
  logic        stall_mem, rf_enM, misalignedM;
  logic [1:0]  wb_selM;
  logic [4:0]  rdM;
  logic [31:0] alu_outM, load_dataM;
`ifdef LSU_TIMEOUT_EN
  logic        bus_errM;
`endif

  mem_stage_lsu_if #(.XLEN(32)) bus ();

  mem_stage_lsu #(
    .XLEN(32)
`ifdef LSU_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .flushE(flushE), .rf_enE(rf_enE), .wb_selE(wb_selE),
    .mem_rdE(mem_rdE), .mem_wrE(mem_wrE), .funct3E(funct3E), .alu_outE(alu_outE),
    .store_dataE(store_dataE), .rdE(rdE), .stall_mem(stall_mem), .rf_enM(rf_enM),
    .wb_selM(wb_selM), .rdM(rdM), .alu_outM(alu_outM), .load_dataM(load_dataM),
    .misalignedM(misalignedM),
`ifdef LSU_TIMEOUT_EN
    .bus_errM(bus_errM),
`endif
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd, wr, rfen;
    logic [1:0]  wbsel;
    logic [2:0]  f3;
    logic [31:0] addr, sdata;
    logic [4:0]  rdst;
  } op_t;

  typedef struct {
    op_t         o;
    int          w;
    logic [31:0] rdata;
    logic        misal, rfen;
    logic [31:0] ld;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference model: sizes, legality and lane data from plain arithmetic.
  function automatic int unsigned msize(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit op_legal(input op_t o);
    bit ok;
    if (!o.rd && !o.wr) return 1'b1;
    ok = o.rd ? (o.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (o.f3 inside {3'd0, 3'd1, 3'd2});
    return ok && ((o.addr % msize(o.f3)) == 0);
  endfunction

  function automatic logic [31:0] m_load(input op_t o, input logic [31:0] rdata);
    int unsigned sz;
    logic [31:0] s;
    longint v, range;
    sz = msize(o.f3);
    if (sz == 4) return rdata;
    s = rdata >> (8 * (o.addr % 4));
    range = longint'(1) << (8 * sz);
    v = longint'(s) % range;
    if (!o.f3[2] && v >= range / 2) v = v - range;
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_be(input op_t o);
    return ((32'd1 << msize(o.f3)) - 1) << (o.addr % 4);
  endfunction

  function automatic logic [31:0] m_wdata(input op_t o);
    case (msize(o.f3))
      1:       return (o.sdata % 256) * 32'h01010101;
      2:       return (o.sdata % 65536) * 32'h00010001;
      default: return o.sdata;
    endcase
  endfunction

  task automatic drive(input op_t o, input logic fl);
    flushE = fl; rf_enE = o.rfen; wb_selE = o.wbsel; mem_rdE = o.rd; mem_wrE = o.wr;
    funct3E = o.f3; alu_outE = o.addr; store_dataE = o.sdata; rdE = o.rdst;
  endtask

  function automatic op_t rand_op();
    op_t o;
    int kind;
    kind = $urandom_range(0, 2);
    o.addr = $urandom; o.sdata = $urandom; o.rdst = 5'($urandom);
    o.rd = (kind == 1); o.wr = (kind == 2);
    o.f3 = (kind == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom);
    o.rfen  = (kind == 2) ? 1'b0 : 1'($urandom);
    o.wbsel = (kind == 1) ? 2'b10 : ((kind == 2) ? 2'b00 : 2'($urandom_range(0, 1)));
    return o;
  endfunction

  // Called at edge+1 with a bubble held; returns at edge+1 with a bubble captured.
  task automatic run_op(input op_t o, input int w);
    logic [31:0] rdata;
    chk("idle_rf_en", rf_enM, 0);
    chk("idle_req", bus.bus_req, 0);
    drive(o, 1'b0);
    bus.bus_ready = 1'b0;
    @(posedge clk); #1;
    drive(rand_op(), 1'b1);
    if ((o.rd || o.wr) && op_legal(o)) begin
      for (int i = 0; i < w; i++) begin
        bus.bus_rdata = $urandom;
        #1;
        chk("wait_stall", stall_mem, 1);
        chk("wait_req", bus.bus_req, 1);
        chk("wait_rf_en", rf_enM, 0);
        chk("wait_wb_sel", wb_selM, 0);
        chk("wait_hold_addr", alu_outM, o.addr);
        @(posedge clk); #1;
      end
      rdata = $urandom;
      bus.bus_ready = 1'b1; bus.bus_rdata = rdata;
      #1;
      chk("done_stall", stall_mem, 0);
      chk("done_we", bus.bus_we, o.wr);
      chk("done_addr", bus.bus_addr, o.addr & 32'hFFFF_FFFC);
      chk("done_rf_en", rf_enM, o.rfen);
      chk("done_wb_sel", wb_selM, o.wbsel);
      chk("done_rd", rdM, o.rdst);
      if (o.rd) chk("done_load", load_dataM, m_load(o, rdata));
      else begin
        chk("done_be", bus.bus_be, m_be(o));
        chk("done_wdata", bus.bus_wdata, m_wdata(o));
      end
    end else if (o.rd || o.wr) begin
      #1;
      chk("ill_misal", misalignedM, 1);
      chk("ill_req", bus.bus_req, 0);
      chk("ill_stall", stall_mem, 0);
      chk("ill_rf_en", rf_enM, 0);
    end else begin
      #1;
      chk("alu_rf_en", rf_enM, o.rfen);
      chk("alu_wb_sel", wb_selM, o.wbsel);
      chk("alu_out", alu_outM, o.addr);
      chk("alu_stall", stall_mem, 0);
      chk("alu_req", bus.bus_req, 0);
      chk("alu_load", load_dataM, 0);
    end
    @(posedge clk); #1;
    bus.bus_ready = 1'b0;
  endtask

  vec_t vt[13];
  op_t  bub;

  initial begin
    vt[0]  = '{'{0,0,1,2'b00,3'b000,32'h0000_1234,32'h0,5'd3}, 0, 32'h0,         0, 1, 32'h0,         4'h0, 32'h0};
    vt[1]  = '{'{1,0,1,2'b10,3'b010,32'h0000_0100,32'h0,5'd5}, 3, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 4'h0, 32'h0};
    vt[2]  = '{'{1,0,1,2'b10,3'b000,32'h0000_0103,32'h0,5'd6}, 0, 32'h80FF_0000, 0, 1, 32'hFFFF_FF80, 4'h0, 32'h0};
    vt[3]  = '{'{1,0,1,2'b10,3'b100,32'h0000_0103,32'h0,5'd7}, 0, 32'h80FF_0000, 0, 1, 32'h0000_0080, 4'h0, 32'h0};
    vt[4]  = '{'{1,0,1,2'b10,3'b001,32'h0000_0102,32'h0,5'd8}, 0, 32'h80FF_0000, 0, 1, 32'hFFFF_80FF, 4'h0, 32'h0};
    vt[5]  = '{'{1,0,1,2'b10,3'b101,32'h0000_0102,32'h0,5'd9}, 1, 32'h80FF_0000, 0, 1, 32'h0000_80FF, 4'h0, 32'h0};
    vt[6]  = '{'{0,1,0,2'b00,3'b001,32'h0000_0202,32'h1234_ABCD,5'd0}, 0, 32'h0, 0, 0, 32'h0, 4'b1100, 32'hABCD_ABCD};
    vt[7]  = '{'{0,1,0,2'b00,3'b000,32'h0000_0101,32'h0000_005A,5'd0}, 1, 32'h0, 0, 0, 32'h0, 4'b0010, 32'h5A5A_5A5A};
    vt[8]  = '{'{0,1,0,2'b00,3'b010,32'h0000_0204,32'hCAFE_F00D,5'd0}, 2, 32'h0, 0, 0, 32'h0, 4'b1111, 32'hCAFE_F00D};
    vt[9]  = '{'{1,0,1,2'b10,3'b010,32'h0000_0101,32'h0,5'd4}, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0};
    vt[10] = '{'{1,0,1,2'b10,3'b110,32'h0000_0100,32'h0,5'd4}, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0};
    vt[11] = '{'{0,1,0,2'b00,3'b011,32'h0000_0100,32'h0,5'd0}, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0};
    vt[12] = '{'{0,1,0,2'b00,3'b001,32'h0000_0201,32'h0,5'd0}, 0, 32'h0, 1, 0, 32'h0, 4'h0, 32'h0};
    bub = '{0,0,0,2'b00,3'b000,32'h0,32'h0,5'd0};

    rst = 1'b1;
    drive(bub, 1'b0);
    bus.bus_ready = 1'b0; bus.bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_stall", stall_mem, 0);
    chk("rst_req", bus.bus_req, 0);
    chk("rst_rf_en", rf_enM, 0);
    chk("rst_alu_out", alu_outM, 0);
    chk("rst_load", load_dataM, 0);
    chk("rst_misal", misalignedM, 0);

    // Directed table
    foreach (vt[k]) begin
      drive(vt[k].o, 1'b0);
      @(posedge clk); #1;
      drive(rand_op(), 1'b1);
      for (int i = 0; i < vt[k].w; i++) begin
        #1;
        chk($sformatf("v%0d_stall", k), stall_mem, 1);
        chk($sformatf("v%0d_wait_rf_en", k), rf_enM, 0);
        @(posedge clk); #1;
      end
      bus.bus_ready = 1'b1; bus.bus_rdata = vt[k].rdata;
      #1;
      chk($sformatf("v%0d_stall_done", k), stall_mem, 0);
      chk($sformatf("v%0d_misal", k), misalignedM, vt[k].misal);
      chk($sformatf("v%0d_rf_en", k), rf_enM, vt[k].rfen);
      chk($sformatf("v%0d_load", k), load_dataM, vt[k].ld);
      chk($sformatf("v%0d_be", k), bus.bus_be, vt[k].be);
      chk($sformatf("v%0d_req", k), bus.bus_req,
          !vt[k].misal && (vt[k].o.rd || vt[k].o.wr));
      if (!vt[k].misal) chk($sformatf("v%0d_wb_sel", k), wb_selM, vt[k].o.wbsel);
      if (!vt[k].misal && vt[k].o.wr) begin
        chk($sformatf("v%0d_we", k), bus.bus_we, 1);
        chk($sformatf("v%0d_wdata", k), bus.bus_wdata, vt[k].wd);
        chk($sformatf("v%0d_addr", k), bus.bus_addr, vt[k].o.addr & 32'hFFFF_FFFC);
      end
      @(posedge clk); #1;
      bus.bus_ready = 1'b0;
    end

    // Reset mid-access drops the request at once and discards the op
    drive(vt[1].o, 1'b0);
    @(posedge clk); #1;
    drive(bub, 1'b0);
    #1;
    chk("mid_req_before", bus.bus_req, 1);
    chk("mid_stall_before", stall_mem, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", bus.bus_req, 0);
    chk("mid_rst_stall", stall_mem, 0);
    chk("mid_rst_rf_en", rf_enM, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op('{0,0,1,2'b00,3'b000,32'h0000_00AD,32'h0,5'd1}, 0);

`ifdef LSU_TIMEOUT_EN
    // Bus never answers: four stalled cycles, then a one-cycle abort
    drive('{1,0,1,2'b10,3'b010,32'h0000_0300,32'h0,5'd2}, 1'b0);
    @(posedge clk); #1;
    drive(bub, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_stall", stall_mem, 1);
      chk("to_err_early", bus_errM, 0);
      @(posedge clk); #1;
    end
    #1;
    chk("to_err", bus_errM, 1);
    chk("to_req", bus.bus_req, 0);
    chk("to_stall_end", stall_mem, 0);
    chk("to_rf_en", rf_enM, 0);
    @(posedge clk); #1;
    chk("to_err_pulse", bus_errM, 0);
    chk("to_req_after", bus.bus_req, 0);
`endif

    // Randomized ops against the reference model
    for (int n = 0; n < 80; n++) run_op(rand_op(), $urandom_range(0, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
